// File: rtl/common_dffram_arb2.sv
// -----------------------------------------------------------------------------
// common_dffram_arb2
//
// Two-requester round-robin arbiter and clear sequencer placed directly in
// front of one single-port, bit-write-enable DFF RAM. Each granted access
// returns a registered response one cycle later, carrying the word the RAM
// held before the access (read-before-write).
//
// Optional feature macro: COMMON_DFFRAM_ARB2_CLEAR_EN
//   defined   : CLEAR state + sweep counter overwrite every entry with
//               CLEAR_VALUE after a single-cycle clr pulse.
//   undefined : only the SERVE behaviour exists; clr is ignored and
//               clr_busy / clr_done are tied low.
//
// Ports
//   clk                 sole clock, rising edge
//   reset               asynchronous, active-low reset
//   req_valid[1:0]      per-requester request valid
//   req_ready[1:0]      per-requester grant (combinational)
//   req_addr0/1         access address
//   req_we0/1           bit write mask (all zeros = pure read)
//   req_wdata0/1        write data
//   rsp_valid[1:0]      one-cycle response pulse per requester
//   rsp_rdata           pre-access word of the granted request
//   clr                 single-cycle clear request
//   clr_busy            sweep in progress
//   clr_done            one-cycle pulse after the last entry is written
//   ram_addr/en/we/din  to the RAM, one-to-one
//   ram_dout            from the RAM (combinational read)
// -----------------------------------------------------------------------------
module common_dffram_arb2 #(
   parameter int                        RAM_DATA_WIDTH = 1,
   parameter int                        RAM_ADDR_WIDTH = 1,
   parameter logic [RAM_DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [1:0]                req_valid,
   output logic [1:0]                req_ready,
   input  logic [RAM_ADDR_WIDTH-1:0] req_addr0,
   input  logic [RAM_ADDR_WIDTH-1:0] req_addr1,
   input  logic [RAM_DATA_WIDTH-1:0] req_we0,
   input  logic [RAM_DATA_WIDTH-1:0] req_we1,
   input  logic [RAM_DATA_WIDTH-1:0] req_wdata0,
   input  logic [RAM_DATA_WIDTH-1:0] req_wdata1,
   output logic [1:0]                rsp_valid,
   output logic [RAM_DATA_WIDTH-1:0] rsp_rdata,
   input  logic                      clr,
   output logic                      clr_busy,
   output logic                      clr_done,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
   output logic                      ram_en,
   output logic [RAM_DATA_WIDTH-1:0] ram_we,
   output logic [RAM_DATA_WIDTH-1:0] ram_din,
   input  logic [RAM_DATA_WIDTH-1:0] ram_dout
);

   logic                      in_serve;    // arbitration allowed this cycle
   logic                      sweeping;    // RAM port owned by the clear sweep
   logic [RAM_ADDR_WIDTH-1:0] sweep_addr;

   logic [1:0]                grant;
   logic                      last_q, last_d;      // requester granted last
   logic [1:0]                rsp_valid_q, rsp_valid_d;
   logic [RAM_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef COMMON_DFFRAM_ARB2_CLEAR_EN
   localparam logic SERVE = 1'b0;
   localparam logic CLEAR = 1'b1;

   logic                      state_q, state_d;
   logic [RAM_ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                      clr_done_q, clr_done_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      clr_done_d = 1'b0;
      case (state_q)
         SERVE: begin
            // A grant in this same cycle still completes; the sweep starts
            // on the following cycle.
            if (clr) state_d = CLEAR;
         end
         CLEAR: begin
            // clr is deliberately not looked at here: no queuing.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
               state_d    = SERVE;
               cnt_d      = '0;
               clr_done_d = 1'b1;
            end
         end
         default: state_d = SERVE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= SERVE;
         cnt_q      <= '0;
         clr_done_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples the pre-edge values of its neighbours.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         clr_done_q <= clr_done_d;
      end
   end

   assign in_serve   = (state_q == SERVE);
   assign sweeping   = (state_q == CLEAR);
   assign sweep_addr = cnt_q;
   assign clr_busy   = (state_q == CLEAR);
   assign clr_done   = clr_done_q;
`else
   logic                      unused_clr;
   logic [RAM_DATA_WIDTH-1:0] unused_clear_value;

   assign unused_clr         = clr;
   assign unused_clear_value = CLEAR_VALUE;
   assign in_serve           = 1'b1;
   assign sweeping           = 1'b0;
   assign sweep_addr         = '0;
   assign clr_busy           = 1'b0;
   assign clr_done           = 1'b0;
`endif

   // Round robin: a lone requester always wins; on a tie the one that was
   // not granted last wins. last_q resets to 1 so requester 0 wins first.
   always_comb begin
      grant = 2'b00;
      if (in_serve) begin
         if (req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
         else                    grant = req_valid;
      end
   end

   assign req_ready = grant;

   always_comb begin
      ram_en   = 1'b0;
      ram_addr = '0;
      ram_we   = '0;
      ram_din  = '0;
      if (sweeping) begin
         ram_en   = 1'b1;
         ram_addr = sweep_addr;
         ram_we   = '1;
`ifdef COMMON_DFFRAM_ARB2_CLEAR_EN
         ram_din  = CLEAR_VALUE;
`endif
      end else if (grant[0]) begin
         ram_en   = 1'b1;
         ram_addr = req_addr0;
         ram_we   = req_we0;
         ram_din  = req_wdata0;
      end else if (grant[1]) begin
         ram_en   = 1'b1;
         ram_addr = req_addr1;
         ram_we   = req_we1;
         ram_din  = req_wdata1;
      end
   end

   // ram_dout is sampled on the same edge that commits the write, so the
   // response carries the word as it was before this access.
   always_comb begin
      last_d      = last_q;
      rsp_valid_d = grant;
      rsp_rdata_d = rsp_rdata_q;
      if (grant[1])      last_d = 1'b1;
      else if (grant[0]) last_d = 1'b0;
      if (grant != 2'b00) rsp_rdata_d = ram_dout;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q      <= 1'b1;
         rsp_valid_q <= 2'b00;
         rsp_rdata_q <= '0;
      end else begin
         last_q      <= last_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule
